pkt_tx_fmb: RTL

Packet transmit framer for the EER-RL node datapath. On a one-cycle start request it snapshots the node's routing state and emits one packet as a stream of 16-bit words over a valid/ready link to the radio/MAC buffer. Packet types are heartbeat, cluster-head announce and data. Word layout matches the field set the receive-side Q-table update block extracts: source ID, hops, Q-value, energy left, hops from CH and chosen CH.

---
 rtl/pkt_pkg.sv | 52 +++++
 rtl/pkt_word_mux.sv | 59 +++++
 rtl/pkt_tx_fmb.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/pkt_pkg.sv
// Shared packet definitions for the EER-RL framer and the receive-side Q-table block.
// Header word: [15:12] type, [11:8] LEN (words incl. header, excl. checksum), [7:0] seq.
package pkt_pkg;

    localparam int WORD_WIDTH = 16;
    localparam int SEQ_WIDTH  = 8;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        HB   = 2'd1,
        DATA = 2'd2,
        CHA  = 2'd3
    } pkt_type_e;

    localparam logic [3:0] LEN_HB   = 4'd7;
    localparam logic [3:0] LEN_DATA = 4'd6;
    localparam logic [3:0] LEN_CHA  = 4'd5;

    localparam int HDR_TYPE_LSB = 12;
    localparam int HDR_LEN_LSB  = 8;
    localparam int HDR_SEQ_LSB  = 0;

    typedef struct packed {
        logic [WORD_WIDTH-1:0] myID;
        logic [WORD_WIDTH-1:0] myHops;
        logic [WORD_WIDTH-1:0] myQValue;
        logic [WORD_WIDTH-1:0] myEnergy;
        logic [WORD_WIDTH-1:0] hopsFromCH;
        logic [WORD_WIDTH-1:0] chosenCH;
        logic [WORD_WIDTH-1:0] chosenHop;
        logic [WORD_WIDTH-1:0] payload;
    } node_snap_t;

    function automatic logic [3:0] pktLen(pkt_type_e t);
        case (t)
            HB:      return LEN_HB;
            DATA:    return LEN_DATA;
            CHA:     return LEN_CHA;
            default: return 4'd0;
        endcase
    endfunction

    function automatic logic [WORD_WIDTH-1:0] packHeader(pkt_type_e t, logic [SEQ_WIDTH-1:0] seq);
        logic [WORD_WIDTH-1:0] h;
        h = '0;
        h[HDR_TYPE_LSB +: 4]        = {2'b00, t};
        h[HDR_LEN_LSB +: 4]         = pktLen(t);
        h[HDR_SEQ_LSB +: SEQ_WIDTH] = seq;
        return h;
    endfunction

endpackage

// File: rtl/pkt_word_mux.sv
// Combinational packet word selection by (type, word index) from the latched node snapshot.
module pkt_word_mux
    import pkt_pkg::*;
(
    input  logic [1:0]            pktType,
    input  logic [3:0]            idx,
    input  logic [SEQ_WIDTH-1:0]  seq,
    input  logic [WORD_WIDTH-1:0] myID,
    input  logic [WORD_WIDTH-1:0] myHops,
    input  logic [WORD_WIDTH-1:0] myQValue,
    input  logic [WORD_WIDTH-1:0] myEnergy,
    input  logic [WORD_WIDTH-1:0] hopsFromCH,
    input  logic [WORD_WIDTH-1:0] chosenCH,
    input  logic [WORD_WIDTH-1:0] chosenHop,
    input  logic [WORD_WIDTH-1:0] payload,
    output logic [WORD_WIDTH-1:0] word
);

    always_comb begin
        word = '0;
        case (pkt_type_e'(pktType))
            HB: begin
                case (idx)
                    4'd0:    word = packHeader(HB, seq);
                    4'd1:    word = myID;
                    4'd2:    word = myHops;
                    4'd3:    word = myQValue;
                    4'd4:    word = myEnergy;
                    4'd5:    word = hopsFromCH;
                    4'd6:    word = chosenCH;
                    default: word = '0;
                endcase
            end
            DATA: begin
                case (idx)
                    4'd0:    word = packHeader(DATA, seq);
                    4'd1:    word = myID;
                    4'd2:    word = chosenHop;
                    4'd3:    word = myQValue;
                    4'd4:    word = myEnergy;
                    4'd5:    word = payload;
                    default: word = '0;
                endcase
            end
            CHA: begin
                case (idx)
                    4'd0:    word = packHeader(CHA, seq);
                    4'd1:    word = myID;
                    4'd2:    word = myHops;
                    4'd3:    word = myQValue;
                    4'd4:    word = myEnergy;
                    default: word = '0;
                endcase
            end
            default: word = '0;
        endcase
    end

endmodule

// File: rtl/pkt_tx_fmb.sv
// Packet transmit framer: snapshots node state on start and streams one packet over valid/ready.
// Optional macro PKT_CHECKSUM_EN appends an XOR-of-all-words checksum beat.
//
// state | meaning
// IDLE  | waiting for start, start_ready=1
// SEND  | streaming words, index advances on each beat
// DONE  | one-cycle tx_done, seq increments
module pkt_tx_fmb
    import pkt_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            pktType,
    input  logic [WORD_WIDTH-1:0] myID,
    input  logic [WORD_WIDTH-1:0] myHops,
    input  logic [WORD_WIDTH-1:0] myQValue,
    input  logic [WORD_WIDTH-1:0] myEnergy,
    input  logic [WORD_WIDTH-1:0] hopsFromCH,
    input  logic [WORD_WIDTH-1:0] chosenCH,
    input  logic [WORD_WIDTH-1:0] chosenHop,
    input  logic [WORD_WIDTH-1:0] payload,
    output logic                  start_ready,
    output logic [WORD_WIDTH-1:0] tx_word,
    output logic                  tx_valid,
    output logic                  tx_last,
    input  logic                  tx_ready,
    output logic                  tx_done,
    output logic                  type_err
);

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_e;

    state_e                state, nextState;
    pkt_type_e             typeQ;
    node_snap_t            snap;
    logic [SEQ_WIDTH-1:0]  seq;
    logic [3:0]            idx;
    logic [3:0]            lastIdx;
    logic                  typeErrQ;
    logic                  accept;
    logic                  beat;
    logic                  lastWord;
    logic [WORD_WIDTH-1:0] fieldWord;
`ifdef PKT_CHECKSUM_EN
    logic [WORD_WIDTH-1:0] csum;
`endif

    assign accept   = (state == IDLE) && start && (pktType != 2'd0);
    assign beat     = tx_valid & tx_ready;
    assign lastWord = (idx == lastIdx);
    assign tx_last  = tx_valid & lastWord;
    assign type_err = typeErrQ;

    pkt_word_mux uMux (
        .pktType    (typeQ),
        .idx        (idx),
        .seq        (seq),
        .myID       (snap.myID),
        .myHops     (snap.myHops),
        .myQValue   (snap.myQValue),
        .myEnergy   (snap.myEnergy),
        .hopsFromCH (snap.hopsFromCH),
        .chosenCH   (snap.chosenCH),
        .chosenHop  (snap.chosenHop),
        .payload    (snap.payload),
        .word       (fieldWord)
    );

    // With checksum the extra beat sits at index LEN, just past the last field.
`ifdef PKT_CHECKSUM_EN
    assign lastIdx = pktLen(typeQ);
    always_comb begin
        tx_word = '0;
        if (tx_valid)
            tx_word = (idx == pktLen(typeQ)) ? csum : fieldWord;
    end
`else
    assign lastIdx = pktLen(typeQ) - 4'd1;
    always_comb begin
        tx_word = '0;
        if (tx_valid)
            tx_word = fieldWord;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    always_comb begin
        nextState   = state;
        start_ready = 1'b0;
        tx_valid    = 1'b0;
        tx_done     = 1'b0;
        case (state)
            IDLE: begin
                start_ready = 1'b1;
                if (accept) nextState = SEND;
            end
            SEND: begin
                tx_valid = 1'b1;
                if (tx_ready && lastWord) nextState = DONE;
            end
            DONE: begin
                tx_done   = 1'b1;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            typeQ    <= NONE;
            snap     <= '0;
            seq      <= '0;
            idx      <= '0;
            typeErrQ <= 1'b0;
`ifdef PKT_CHECKSUM_EN
            csum     <= '0;
`endif
        end else begin
            typeErrQ <= (state == IDLE) && start && (pktType == 2'd0);
            if (accept) begin
                typeQ <= pkt_type_e'(pktType);
                snap  <= '{myID: myID, myHops: myHops, myQValue: myQValue, myEnergy: myEnergy,
                           hopsFromCH: hopsFromCH, chosenCH: chosenCH, chosenHop: chosenHop,
                           payload: payload};
                idx   <= '0;
`ifdef PKT_CHECKSUM_EN
                csum  <= '0;
`endif
            end else if (beat) begin
                idx   <= idx + 4'd1;
`ifdef PKT_CHECKSUM_EN
                csum  <= csum ^ tx_word;
`endif
            end
            if (state == DONE)
                seq <= seq + SEQ_WIDTH'(1);
        end
    end

endmodule
